pwm_multi_ch: RTL and testbench

Multi-channel, double-buffered PWM generator: the parametrised successor to the single-channel 4-bit PWM block. All CHANNELS outputs share one counter and one programmable prescaler, and each channel has its own duty register. Duty and period changes are buffered and take effect only at a period boundary, so outputs never glitch. The block sits between the ui_in/host register write path and the uo_out pins.

---
 rtl/pwm_multi_ch.sv | 164 ++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch
//   Multi-channel double-buffered PWM generator. All channels share one
//   prescaler and one counter; each channel compares the counter against its
//   own active duty value. Duty writes land in shadow registers and, along
//   with the period input, are copied to the active registers only at the
//   period boundary (wrap), so an output never changes mid-period.
//
//   Optional build macro: PWM_CENTER_ALIGN_EN
//     undefined : edge-aligned up-counter, 0..act_period then wrap to 0
//     defined   : up/down counter; each end value is held for one tick and
//                 the wrap (buffer load, period_start) happens at the bottom
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active-high
//   enable        run enable; low holds prescaler/counter at 0, outputs low,
//                 and keeps the active registers tracking shadow/period
//   prescale      a counter tick occurs every prescale+1 clocks
//   period        counter top value, sampled at wrap (or while disabled)
//   wr_en         write strobe for one duty shadow register
//   wr_ch         shadow register selected; values >= CHANNELS are ignored
//   wr_duty       duty value in ticks high per period
//   pwm_out       registered PWM outputs, one per channel
//   period_start  one-clock pulse, registered copy of the wrap event
module pwm_multi_ch #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned BITS     = 8,
  parameter int unsigned PRESC_W  = 8,
  parameter int unsigned CH_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic [BITS-1:0]     period,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [BITS-1:0]     wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  logic [PRESC_W-1:0]  presc;
  logic [PRESC_W-1:0]  presc_next;
  logic [BITS-1:0]     cnt;
  logic [BITS-1:0]     cnt_next;
  logic [BITS-1:0]     act_period;
  logic [BITS-1:0]     shadow   [CHANNELS];
  logic [BITS-1:0]     act_duty [CHANNELS];
  logic [CHANNELS-1:0] pwm_next;
  logic                tick;
  logic                wrap;
  logic                load;

  // Prescaler: counts 0..prescale, tick on the compare. A prescale change is
  // not buffered and simply applies at the next compare.
  always_comb begin
    tick       = enable && (presc == prescale);
    presc_next = presc + PRESC_W'(1);
    if (!enable || tick) begin
      presc_next = '0;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  dir_t dir;
  dir_t dir_next;

  // Up/down counter. Reaching either end flips the direction without moving
  // the count, so both end values last one full tick. The wrap is the held
  // bottom value, where the next tick starts counting up again.
  always_comb begin
    dir_next = dir;
    cnt_next = cnt;
    wrap     = tick && (dir == DIR_DOWN) && (cnt == '0);
    if (!enable) begin
      dir_next = DIR_UP;
      cnt_next = '0;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (cnt == act_period) begin
          dir_next = DIR_DOWN;
        end else begin
          cnt_next = cnt + BITS'(1);
        end
      end else begin
        if (cnt == '0) begin
          dir_next = DIR_UP;
        end else begin
          cnt_next = cnt - BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir <= DIR_UP;
    end else begin
      dir <= dir_next;
    end
  end
`else
  // Edge-aligned up-counter wrapping to 0 after act_period.
  always_comb begin
    cnt_next = cnt;
    wrap     = tick && (cnt == act_period);
    if (!enable || wrap) begin
      cnt_next = '0;
    end else if (tick) begin
      cnt_next = cnt + BITS'(1);
    end
  end
`endif

  // Active registers follow the buffered values at every wrap and
  // continuously while disabled, so new settings apply as enable rises.
  assign load = wrap || !enable;

  always_comb begin
    pwm_next = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_next[i] = enable && (cnt < act_duty[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc        <= '0;
      cnt          <= '0;
      act_period   <= '1;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow[i]   <= '0;
        act_duty[i] <= '0;
      end
    end else begin
      presc        <= presc_next;
      cnt          <= cnt_next;
      pwm_out      <= pwm_next;
      period_start <= wrap;
      if (load) begin
        act_period <= period;
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        // A write coincident with a load reaches only the shadow; the active
        // register takes the previous shadow value via non-blocking semantics.
        if (wr_en && (32'(wr_ch) == i)) begin
          shadow[i] <= wr_duty;
        end
        if (load) begin
          act_duty[i] <= shadow[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch
//   Directed self-checking bench for pwm_multi_ch (CHANNELS=4, BITS=8).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_pwm_multi_ch;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned BITS     = 8;
  localparam int unsigned PRESC_W  = 8;
  localparam int unsigned CH_W     = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic [PRESC_W-1:0]  prescale;
  logic [BITS-1:0]     period;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [BITS-1:0]     wr_duty;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_start;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  pwm_multi_ch #(
    .CHANNELS (CHANNELS),
    .BITS     (BITS),
    .PRESC_W  (PRESC_W),
    .CH_W     (CH_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .prescale     (prescale),
    .period       (period),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] e;
    int         m;
    int         d3;
    int         c;
    int         seq [10];
    seq = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};

    // Reset state
    rst      = 1'b1;
    enable   = 1'b0;
    prescale = '0;
    period   = 8'd9;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_duty  = '0;
    @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'h0);
    check("reset_ps", 32'(period_start), 32'h0);
    rst = 1'b0;

    // Load shadows while disabled: ch0=3, ch1=0, ch2=12, ch3=5
    wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 8'd3;
    @(negedge clk); check("setup_pwm0", 32'(pwm_out), 32'h0);
    wr_ch = 2'd1; wr_duty = 8'd0;
    @(negedge clk); check("setup_pwm1", 32'(pwm_out), 32'h0);
    wr_ch = 2'd2; wr_duty = 8'd12;
    @(negedge clk); check("setup_pwm2", 32'(pwm_out), 32'h0);
    wr_ch = 2'd3; wr_duty = 8'd5;
    @(negedge clk); check("setup_pwm3", 32'(pwm_out), 32'h0);
    wr_en = 1'b0;
    @(negedge clk); check("setup_ps", 32'(period_start), 32'h0);

    // Edge-aligned run, period 10 clocks; ch3 buffered updates 5 -> 7 -> 2
    enable = 1'b1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      m    = k % 10;
      d3   = (k < 60) ? 5 : ((k < 80) ? 7 : 2);
      e[0] = (m < 3);
      e[1] = 1'b0;
      e[2] = 1'b1;
      e[3] = (m < d3);
      check($sformatf("run_pwm[%0d]", k), 32'(pwm_out), 32'(e));
      check($sformatf("run_ps[%0d]", k), 32'(period_start), 32'(m == 9));
      if (k == 52) begin
        wr_en = 1'b1; wr_ch = 2'd3; wr_duty = 8'd7;
      end
      if (k == 68) begin
        wr_en = 1'b1; wr_ch = 2'd3; wr_duty = 8'd2;
      end
      if (k == 53 || k == 69) begin
        wr_en = 1'b0;
      end
    end

    // Disable for 5 clocks, reconfigure: prescale 3, period 4, ch0 duty 2
    enable   = 1'b0;
    prescale = 8'd3;
    period   = 8'd4;
    wr_en    = 1'b1; wr_ch = 2'd0; wr_duty = 8'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      check($sformatf("dis_pwm[%0d]", k), 32'(pwm_out), 32'h0);
      check($sformatf("dis_ps[%0d]", k), 32'(period_start), 32'h0);
    end

    // Prescaled run: 20-clock period, high 8 clocks on ch0/ch3
    enable = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      c    = (k / 4) % 5;
      e[0] = (c < 2);
      e[1] = 1'b0;
      e[2] = 1'b1;
      e[3] = (c < 2);
      check($sformatf("presc_pwm[%0d]", k), 32'(pwm_out), 32'(e));
      check($sformatf("presc_ps[%0d]", k), 32'(period_start), 32'(k % 20 == 19));
    end

    // Asynchronous reset mid-period
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'h0);
    check("async_rst_ps", 32'(period_start), 32'h0);
    @(negedge clk);
    check("rst_hold_pwm", 32'(pwm_out), 32'h0);
    rst      = 1'b0;
    enable   = 1'b0;
    prescale = 8'd0;
    period   = 8'd3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_dis[%0d]", k), 32'(pwm_out), 32'h0);
    end

    // Restart: all shadows are zero, counter restarts at 0 with period 4
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("restart_pwm[%0d]", k), 32'(pwm_out), 32'h0);
      check($sformatf("restart_ps[%0d]", k), 32'(period_start), 32'(k % 4 == 3));
    end

    // period 4, ch0 duty 2, prescale 0
    enable = 1'b0;
    period = 8'd4;
    wr_en  = 1'b1; wr_ch = 2'd0; wr_duty = 8'd2;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_mode_pwm", 32'(pwm_out), 32'h0);
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
`ifdef PWM_CENTER_ALIGN_EN
      m = k % 10;
      check($sformatf("center_pwm[%0d]", k), 32'(pwm_out), 32'(seq[m] < 2));
      check($sformatf("center_ps[%0d]", k), 32'(period_start), 32'(m == 9));
`else
      m = k % 5;
      check($sformatf("edge_pwm[%0d]", k), 32'(pwm_out), 32'(m < 2));
      check($sformatf("edge_ps[%0d]", k), 32'(period_start), 32'(m == 4));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
